// File: rtl/qspi_matmul_host_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : qspi_mm_pkg
//  Purpose  : Shared types and constants for the QSPI matrix-multiply host:
//             FSM state encoding, transfer lengths and byte-pack helpers.
//  Revision : 1.0  initial release
// ============================================================================
package qspi_mm_pkg;

  // Transaction phases, in the order the host walks through them
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_WRITE = 3'd2,
    ST_TURN  = 3'd3,
    ST_READ  = 3'd4,
    ST_HOLD  = 3'd5
  } state_e;

  // 8 bytes of A/B go out as 16 nibbles, 4 bytes of C come back as 8
  localparam int NIBBLES_WR = 16;
  localparam int NIBBLES_RD = 8;

  // Element 0 sits in the most significant byte of a packed matrix word
  function automatic logic [31:0] pack_bytes(input logic [7:0] e0, input logic [7:0] e1,
                                             input logic [7:0] e2, input logic [7:0] e3);
    return {e0, e1, e2, e3};
  endfunction

  function automatic logic [7:0] unpack_byte(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] r;
    case (idx)
      2'd0:    r = w[31:24];
      2'd1:    r = w[23:16];
      2'd2:    r = w[15:8];
      default: r = w[7:0];
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/qspi_matmul_host_if.sv
`default_nettype none
// ============================================================================
//  Module   : qspi_matmul_host_if
//  Purpose  : QSPI pin bundle between the host (master) and the matmul
//             target (slave): serial clock, chip select, 4-bit data lanes.
//  Revision : 1.0  initial release
// ============================================================================
interface qspi_matmul_host_if;
  logic       qspi_clk;
  logic       qspi_cs_n;
  logic [3:0] qspi_io_out;
  logic [3:0] qspi_io_oe;
  logic [3:0] qspi_io_in;

  modport master (
    output qspi_clk,
    output qspi_cs_n,
    output qspi_io_out,
    output qspi_io_oe,
    input  qspi_io_in
  );

  modport slave (
    input  qspi_clk,
    input  qspi_cs_n,
    input  qspi_io_out,
    input  qspi_io_oe,
    output qspi_io_in
  );
endinterface
`default_nettype wire

// File: rtl/qspi_matmul_host_sck_gen.sv
`default_nettype none
// ============================================================================
//  Module   : qspi_sck_gen
//  Purpose  : Half-period phase counter for the QSPI serial clock. While
//             enabled it counts HALF_PERIOD cycles per clock phase and flags
//             the last cycle of each phase; the caller owns the clock level
//             and feeds it back so the tick can be classified as rise/fall.
//  Revision : 1.0  initial release
// ============================================================================
module qspi_sck_gen #(
  parameter int HALF_PERIOD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic sck_level,
  output logic tick_rise,
  output logic tick_fall,
  output logic tick_last_low
);

  localparam int PW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(HALF_PERIOD - 1);

  logic [PW-1:0] ph_q;
  logic [PW-1:0] ph_d;
  logic          half_end;

  // Next phase count: restart at zero whenever disabled so each enabled
  // stretch begins with a full-length phase
  always_comb begin
    half_end = en && (ph_q == PH_LAST);
    ph_d     = ph_q;
    if (!en || half_end) begin
      ph_d = '0;
    end else begin
      ph_d = ph_q + 1'b1;
    end
  end

  // Phase counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph_q <= '0;
    end else begin
      ph_q <= ph_d;
    end
  end

  // Last cycle of a low phase doubles as the read sample point
  assign tick_rise     = half_end & ~sck_level;
  assign tick_fall     = half_end & sck_level;
  assign tick_last_low = half_end & ~sck_level;

endmodule
`default_nettype wire

// File: rtl/qspi_matmul_host.sv
`default_nettype none
// ============================================================================
//  Module   : qspi_matmul_host
//  Purpose  : QSPI initiator for the 2x2 matrix-multiply target. Serialises
//             A and B as 16 nibbles, turns the bus around, reads 8 result
//             nibbles back and presents C in parallel with a done pulse.
//  Options  : QSPI_HOST_ABORT_EN adds an abort input and a sticky aborted
//             output; without it every transaction runs to completion.
//  Revision : 1.0  initial release
// ============================================================================
module qspi_matmul_host
  import qspi_mm_pkg::*;
#(
  parameter int HALF_PERIOD = 4,
  parameter int CS_SETUP    = 2,
  parameter int TURN_CYCLES = 4,
  parameter int CS_HIGH     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] c_out,
`ifdef QSPI_HOST_ABORT_EN
  input  logic        abort,
  output logic        aborted,
`endif
  qspi_matmul_host_if.master qspi
);

  // One shared down-time counter covers SETUP, TURN and HOLD
  localparam int CNT_MAX = (CS_SETUP > TURN_CYCLES)
                         ? ((CS_SETUP > CS_HIGH) ? CS_SETUP : CS_HIGH)
                         : ((TURN_CYCLES > CS_HIGH) ? TURN_CYCLES : CS_HIGH);
  localparam int CW = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] TURN_LAST  = CW'(TURN_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HIGH - 1);
  localparam logic [3:0]    WR_LAST    = 4'(NIBBLES_WR - 1);
  localparam logic [3:0]    RD_LAST    = 4'(NIBBLES_RD - 1);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    nib_q;
  logic [59:0]   wr_sr_q;   // nibbles 1..15; nibble 0 goes straight to io_out
  logic [31:0]   rd_sr_q;
  logic          qspi_clk_q;
  logic          cs_n_q;
  logic [3:0]    io_out_q;
  logic [3:0]    io_oe_q;
  logic          busy_q;
  logic          done_q;
  logic [31:0]   c_out_q;
`ifdef QSPI_HOST_ABORT_EN
  logic          aborted_q;
`endif

  logic sck_en;
  logic tick_rise;
  logic tick_fall;
  logic tick_last_low;

  // The serial clock only toggles while data is moving
  assign sck_en = (state_q == ST_WRITE) || (state_q == ST_READ);

  qspi_sck_gen #(
    .HALF_PERIOD (HALF_PERIOD)
  ) u_sck_gen (
    .clk           (clk),
    .rst           (rst),
    .en            (sck_en),
    .sck_level     (qspi_clk_q),
    .tick_rise     (tick_rise),
    .tick_fall     (tick_fall),
    .tick_last_low (tick_last_low)
  );

  // Transaction sequencer: every pin and status output is a flop set here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      nib_q      <= '0;
      wr_sr_q    <= '0;
      rd_sr_q    <= '0;
      qspi_clk_q <= 1'b0;
      cs_n_q     <= 1'b1;
      io_out_q   <= '0;
      io_oe_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      c_out_q    <= '0;
`ifdef QSPI_HOST_ABORT_EN
      aborted_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            wr_sr_q  <= {a_in[27:0], b_in};
            io_out_q <= a_in[31:28];
            io_oe_q  <= 4'hF;
            cs_n_q   <= 1'b0;
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            nib_q    <= '0;
            state_q  <= ST_SETUP;
`ifdef QSPI_HOST_ABORT_EN
            aborted_q <= 1'b0;
`endif
          end
        end

        ST_SETUP: begin
          if (cnt_q == SETUP_LAST) begin
            cnt_q   <= '0;
            state_q <= ST_WRITE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        // Data changes only on the first low cycle, so it is stable across
        // the whole high phase when the target samples it
        ST_WRITE: begin
          if (tick_rise) begin
            qspi_clk_q <= 1'b1;
          end else if (tick_fall) begin
            qspi_clk_q <= 1'b0;
            if (nib_q == WR_LAST) begin
              nib_q    <= '0;
              cnt_q    <= '0;
              io_oe_q  <= '0;
              io_out_q <= '0;
              state_q  <= ST_TURN;
            end else begin
              nib_q    <= nib_q + 1'b1;
              io_out_q <= wr_sr_q[59:56];
              wr_sr_q  <= {wr_sr_q[55:0], 4'h0};
            end
          end
        end

        // Bus released; the target uses this gap to compute C
        ST_TURN: begin
          if (cnt_q == TURN_LAST) begin
            cnt_q      <= '0;
            qspi_clk_q <= 1'b1;
            state_q    <= ST_READ;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        // Target drives on the rising edge; sample as late as possible
        ST_READ: begin
          if (tick_fall) begin
            qspi_clk_q <= 1'b0;
          end else if (tick_last_low) begin
            rd_sr_q <= {rd_sr_q[27:0], qspi.qspi_io_in};
            if (nib_q == RD_LAST) begin
              nib_q   <= '0;
              cnt_q   <= '0;
              cs_n_q  <= 1'b1;
              state_q <= ST_HOLD;
            end else begin
              nib_q      <= nib_q + 1'b1;
              qspi_clk_q <= 1'b1;
            end
          end
        end

        ST_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
`ifdef QSPI_HOST_ABORT_EN
            if (!aborted_q) begin
              c_out_q <= rd_sr_q;
            end
`else
            c_out_q <= rd_sr_q;
`endif
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase

`ifdef QSPI_HOST_ABORT_EN
      // Abort overrides whatever the active phase decided this cycle
      if (abort && (state_q == ST_SETUP || state_q == ST_WRITE ||
                    state_q == ST_TURN  || state_q == ST_READ)) begin
        cs_n_q     <= 1'b1;
        qspi_clk_q <= 1'b0;
        io_oe_q    <= '0;
        nib_q      <= '0;
        cnt_q      <= '0;
        aborted_q  <= 1'b1;
        state_q    <= ST_HOLD;
      end
`endif
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign c_out = c_out_q;
`ifdef QSPI_HOST_ABORT_EN
  assign aborted = aborted_q;
`endif

  assign qspi.qspi_clk    = qspi_clk_q;
  assign qspi.qspi_cs_n   = cs_n_q;
  assign qspi.qspi_io_out = io_out_q;
  assign qspi.qspi_io_oe  = io_oe_q;

endmodule
`default_nettype wire
